apb_master_s05_bridge: RTL
==========================

APB_MASTER_S05_BRIDGE -- requirements
Module: apb_master_s05_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter APB_STROBE_WIDTH, default 4, equal to APB_DATA_WIDTH/8.
REQ-004 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries, power of two, at least 2.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles, range 1..255.
REQ-006 SHALL have port pclk  in  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port presetn  in  1  reset, asynchronous assertion, active-low.
REQ-008 SHALL have port cmd_valid  in  1  command offered.
REQ-009 SHALL have port cmd_ready  out  1  command FIFO can accept.
REQ-010 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-011 SHALL have port cmd_addr  in  APB_ADDR_WIDTH  target address.
REQ-012 SHALL have port cmd_wdata  in  APB_DATA_WIDTH  write data.
REQ-013 SHALL have port cmd_strb  in  APB_STROBE_WIDTH  write byte strobes.
REQ-014 SHALL have port rsp_valid  out  1  response available.
REQ-015 SHALL have port rsp_ready  in  1  response consumed.
REQ-016 SHALL have port rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes and errors.
REQ-017 SHALL have port rsp_err  out  1  PSLVERR or timeout.
REQ-018 SHALL have ports paddr_05, pwdata_05, pstrb_05, pwrite_05, psel_05, penable_05 (out) and pprot_05 (out, 3 bits); widths follow the APB_* parameters; these are the APB4 requester signals to slave port 05.
REQ-019 SHALL have ports pready_05, pslverr_05 (in, 1 bit) and prdata_05 (in, APB_DATA_WIDTH); these are the APB4 completer returns from slave port 05.

Function
REQ-020 A command SHALL be pushed when cmd_valid and cmd_ready are both high at a clock edge; cmd_ready SHALL equal not-full, independent of a same-cycle pop.
REQ-021 FIFO pointers SHALL wrap modulo CMD_DEPTH; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-022 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-023 IDLE->SETUP SHALL occur when the FIFO is non-empty and rsp_valid is low; the head entry SHALL be popped into the APB output registers.
REQ-024 SETUP SHALL last exactly one cycle with psel_05=1 and penable_05=0, then enter ACCESS.
REQ-025 ACCESS SHALL drive psel_05=1 and penable_05=1, holding paddr/pwrite/pwdata/pstrb stable until exit.
REQ-026 In ACCESS with pready_05=1, the FSM SHALL capture prdata_05 (reads only) and pslverr_05 into rsp_rdata and rsp_err, set rsp_valid, drop psel and penable, and return to IDLE.
REQ-027 rsp_valid SHALL hold with its data stable until rsp_ready; it SHALL clear on the handshake edge.
REQ-028 Latency: with an empty FIFO, FSM in IDLE and pready_05=1, a command pushed at edge N SHALL give SETUP in cycle N+1, ACCESS in N+2 and rsp_valid=1 in N+3.
REQ-029 For reads, pstrb_05 and pwdata_05 SHALL be driven 0; pprot_05 SHALL be constant 3'b000.
REQ-030 All APB and rsp outputs SHALL be registered; exactly one response SHALL be produced per accepted command, in command order.

Reset
REQ-031 Reset SHALL clear the FIFO, set the FSM to IDLE, and drive cmd_ready=1 with every other output 0.
REQ-032 Reset mid-transfer SHALL abort the transfer immediately, drop psel_05 and penable_05 asynchronously, and discard all pending commands and responses.

Configuration
REQ-033 With APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if TIMEOUT_CYCLES cycles elapse without pready_05, the FSM SHALL drop psel and penable, post a response with rsp_err=1 and rsp_rdata=0, and return to IDLE.
REQ-034 With APB_TIMEOUT_EN undefined, no counter SHALL exist and ACCESS SHALL wait indefinitely for pready_05.

Verification
REQ-035 The bench SHALL cover: write addr 0x10, data 0xA5A5_0001, strb 0xF, pready=1 -> SETUP/ACCESS one cycle each, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-036 The bench SHALL cover: read 0x10 with a wait state of 3 cycles, prdata=0xA5A5_0001 -> penable high for 4 cycles, rsp_rdata=0xA5A5_0001, pstrb_05=0.
REQ-037 The bench SHALL cover: push 5 commands with rsp_ready=0 -> cmd_ready low after 4 FIFO entries plus 1 in flight; no SETUP while rsp_valid pending; order preserved once drained.
REQ-038 The bench SHALL cover: pslverr_05=1 on completion -> rsp_err=1, rsp_rdata=0, next command proceeds normally.
REQ-039 The bench SHALL cover: APB_TIMEOUT_EN defined, pready_05 held 0 -> after 16 ACCESS cycles psel drops and rsp_err=1; with the macro undefined, psel stays high.
REQ-040 The bench SHALL cover: presetn low during ACCESS with 2 entries queued -> psel_05=0 at once, cmd_ready=1, no response after release.

Source files
------------

// File: rtl/apb_master_s05_bridge.sv
// Command-FIFO fronted APB4 requester for slave port 05: one response per command, in order.
// Optional build macro APB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYCLES cycles.
module apb_master_s05_bridge #(
  parameter int unsigned APB_ADDR_WIDTH   = 32,
  parameter int unsigned APB_DATA_WIDTH   = 32,
  parameter int unsigned APB_STROBE_WIDTH = 4,
  parameter int unsigned CMD_DEPTH        = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 16
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [APB_STROBE_WIDTH-1:0] cmd_strb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_05,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_05,
  output logic [APB_STROBE_WIDTH-1:0] pstrb_05,
  output logic                        pwrite_05,
  output logic                        psel_05,
  output logic                        penable_05,
  output logic [2:0]                  pprot_05,
  input  logic                        pready_05,
  input  logic                        pslverr_05,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_05
);

  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = 8;

  // Elaboration-time parameter sanity checks
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("CMD_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  if (APB_STROBE_WIDTH * 8 != APB_DATA_WIDTH) begin : g_bad_strb
    $error("APB_STROBE_WIDTH must equal APB_DATA_WIDTH/8");
  end

  typedef struct packed {
    logic                        write;
    logic [APB_ADDR_WIDTH-1:0]   addr;
    logic [APB_DATA_WIDTH-1:0]   wdata;
    logic [APB_STROBE_WIDTH-1:0] strb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                      state_q, state_d;
  cmd_t                        mem [CMD_DEPTH];
  cmd_t                        head;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            count, count_d;
  logic                        push, pop;
  logic [APB_ADDR_WIDTH-1:0]   paddr_d;
  logic [APB_DATA_WIDTH-1:0]   pwdata_d, rsp_rdata_d;
  logic [APB_STROBE_WIDTH-1:0] pstrb_d;
  logic                        pwrite_d, psel_d, penable_d, rsp_valid_d, rsp_err_d;
`ifdef APB_TIMEOUT_EN
  logic [TMO_W-1:0]            tmo_q, tmo_d;
`endif

  assign pprot_05 = 3'b000;
  assign push     = cmd_valid && cmd_ready;
  assign head     = mem[rd_ptr];
  assign count_d  = count + CNT_W'(push) - CNT_W'(pop);

  // Command storage; contents need no reset since count gates every read
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_d;
      cmd_ready <= (count_d != CNT_W'(CMD_DEPTH));
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      paddr_05   <= '0;
      pwdata_05  <= '0;
      pstrb_05   <= '0;
      pwrite_05  <= 1'b0;
      psel_05    <= 1'b0;
      penable_05 <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      paddr_05   <= paddr_d;
      pwdata_05  <= pwdata_d;
      pstrb_05   <= pstrb_d;
      pwrite_05  <= pwrite_d;
      psel_05    <= psel_d;
      penable_05 <= penable_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Next state, FIFO pop and next values of the registered APB/response outputs
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    paddr_d     = paddr_05;
    pwdata_d    = pwdata_05;
    pstrb_d     = pstrb_05;
    pwrite_d    = pwrite_05;
    psel_d      = psel_05;
    penable_d   = penable_05;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
`ifdef APB_TIMEOUT_EN
    tmo_d       = '0;
`endif
    if (rsp_valid && rsp_ready) rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0 && !rsp_valid) begin
          pop       = 1'b1;
          paddr_d   = head.addr;
          pwrite_d  = head.write;
          pwdata_d  = head.write ? head.wdata : '0;
          pstrb_d   = head.write ? head.strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_05) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr_05;
          rsp_rdata_d = (pwrite_05 || pslverr_05) ? '0 : prdata_05;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
